// File: rtl/vga_bounce_box.sv
// Bouncing box renderer: moves a square once per frame and colours pixels behind the sync generator.
// Optional macro VGA_BOUNCE_BORDER_EN draws a one-pixel white frame around the active area.
module vga_bounce_box #(
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 2,
    parameter logic [11:0] BG_COLOR = 12'h00F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] sw,
    input  logic        pause,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_tick
);

    localparam logic [10:0] BOX_W   = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] X_LIMIT = 11'd640;
    localparam logic [10:0] Y_LIMIT = 11'd480;

    logic [9:0]  bx;
    logic [9:0]  by;
    logic        dir_x;
    logic        dir_y;
    logic        upd;
    logic [10:0] next_x;
    logic [10:0] next_y;
    logic        in_box;
    logic [11:0] pixel_color;

    // One axis of motion; returns {new_direction, new_position}.
    function automatic logic [10:0] step_axis(input logic [9:0]  pos,
                                              input logic        dir,
                                              input logic [10:0] limit);
        logic [10:0] np;
        logic [10:0] result;
        np = {1'b0, pos} + STEP_W;
        if (dir) begin
            if (np + BOX_W >= limit)
                result = {1'b0, 10'(limit - BOX_W)};
            else
                result = {1'b1, np[9:0]};
        end else begin
            if ({1'b0, pos} <= STEP_W)
                result = {1'b1, 10'd0};
            else
                result = {1'b0, pos - STEP_W[9:0]};
        end
        return result;
    endfunction

    // Line 480 is in vertical blanking, so moving the box there never tears the picture.
    assign upd    = p_tick && (x == 10'd0) && (y == 10'd480);
    assign next_x = step_axis(bx, dir_x, X_LIMIT);
    assign next_y = step_axis(by, dir_y, Y_LIMIT);

    assign in_box = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < {1'b0, bx} + BOX_W) &&
                    ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < {1'b0, by} + BOX_W);

    always_comb begin
        pixel_color = in_box ? sw : BG_COLOR;
`ifdef VGA_BOUNCE_BORDER_EN
        if ((x == 10'd0) || (x == 10'd639) || (y == 10'd0) || (y == 10'd479))
            pixel_color = 12'hFFF;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bx    <= 10'd0;
            by    <= 10'd0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (upd && !pause) begin
            {dir_x, bx} <= next_x;
            {dir_y, by} <= next_y;
        end
    end

    // Pixel pipeline: one p_tick of latency, syncs delayed by the same amount.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb        <= 12'h000;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= upd;
            if (p_tick) begin
                rgb   <= video_on ? pixel_color : 12'h000;
                hsync <= hsync_in;
                vsync <= vsync_in;
            end
        end
    end

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed self-checking bench for vga_bounce_box; frames are shortened to just the update pixel.
// Build with VGA_BOUNCE_BORDER_EN defined to check the border variant.
module tb_vga_bounce_box;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] sw;
    logic        pause;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int ft_count = 0;
    int ft_start;

`ifdef VGA_BOUNCE_BORDER_EN
    localparam logic [11:0] CORNER_EXP = 12'hFFF;
`else
    localparam logic [11:0] CORNER_EXP = 12'hF00;
`endif

    vga_bounce_box dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .sw         (sw),
        .pause      (pause),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_tick) ft_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One pixel tick at (px,py); outputs are valid on return.
    task automatic applyStimulus(input logic [9:0] px, input logic [9:0] py, input logic von,
                                 input logic hs, input logic vs);
        x        = px;
        y        = py;
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        p_tick   = 1'b1;
        tick();
        p_tick   = 1'b0;
    endtask

    task automatic runFrames(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(10'd0, 10'd480, 1'b0, 1'b1, 1'b1);
            y = 10'd0;
            tick();
        end
    endtask

    task automatic checkPos(input string tag, input logic [9:0] ex_bx, input logic ex_dx,
                            input logic [9:0] ex_by, input logic ex_dy);
        checkOutput({tag, " bx"}, {6'd0, dut.bx}, {6'd0, ex_bx});
        checkOutput({tag, " dir_x"}, {15'd0, dut.dir_x}, {15'd0, ex_dx});
        checkOutput({tag, " by"}, {6'd0, dut.by}, {6'd0, ex_by});
        checkOutput({tag, " dir_y"}, {15'd0, dut.dir_y}, {15'd0, ex_dy});
    endtask

    initial begin
        reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; sw = 12'hF00; pause = 1'b0;
        repeat (3) tick();
        checkOutput("reset rgb", {4'd0, rgb}, 16'h0000);
        checkOutput("reset hsync", {15'd0, hsync}, 16'd0);
        checkOutput("reset vsync", {15'd0, vsync}, 16'd0);
        checkOutput("reset frame_tick", {15'd0, frame_tick}, 16'd0);
        checkPos("reset", 10'd0, 1'b1, 10'd0, 1'b1);
        reset = 1'b0;
        tick();

        // Frame 0 pixels, box at (0,0)
        applyStimulus(10'd5, 10'd5, 1'b1, 1'b1, 1'b0);
        checkOutput("px(5,5)", {4'd0, rgb}, 16'h0F00);
        checkOutput("px(5,5) hsync", {15'd0, hsync}, 16'd1);
        checkOutput("px(5,5) vsync", {15'd0, vsync}, 16'd0);
        x = 10'd40; hsync_in = 1'b0; vsync_in = 1'b1;
        tick();
        checkOutput("hold rgb", {4'd0, rgb}, 16'h0F00);
        checkOutput("hold hsync", {15'd0, hsync}, 16'd1);
        applyStimulus(10'd40, 10'd5, 1'b1, 1'b0, 1'b1);
        checkOutput("px(40,5)", {4'd0, rgb}, 16'h000F);
        checkOutput("px(40,5) hsync", {15'd0, hsync}, 16'd0);
        checkOutput("px(40,5) vsync", {15'd0, vsync}, 16'd1);
        applyStimulus(10'd700, 10'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("px(700,5)", {4'd0, rgb}, 16'h0000);
        applyStimulus(10'd31, 10'd31, 1'b1, 1'b0, 1'b0);
        checkOutput("px(31,31)", {4'd0, rgb}, 16'h0F00);
        applyStimulus(10'd32, 10'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("px(32,5)", {4'd0, rgb}, 16'h000F);
        applyStimulus(10'd5, 10'd32, 1'b1, 1'b0, 1'b0);
        checkOutput("px(5,32)", {4'd0, rgb}, 16'h000F);
        applyStimulus(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("px(0,0)", {4'd0, rgb}, {4'd0, CORNER_EXP});
        applyStimulus(10'd1, 10'd1, 1'b1, 1'b0, 1'b0);
        checkOutput("px(1,1)", {4'd0, rgb}, 16'h0F00);

        // Move a few frames, then reset in the middle of a line
        runFrames(5);
        checkPos("5 frames", 10'd10, 1'b1, 10'd10, 1'b1);
        applyStimulus(10'd12, 10'd12, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("midreset rgb", {4'd0, rgb}, 16'h0000);
        checkOutput("midreset hsync", {15'd0, hsync}, 16'd0);
        checkOutput("midreset vsync", {15'd0, vsync}, 16'd0);
        checkOutput("midreset bx", {6'd0, dut.bx}, 16'd0);
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        checkOutput("first frame_tick", {15'd0, frame_tick}, 16'd1);
        checkPos("first upd", 10'd2, 1'b1, 10'd2, 1'b1);
        y = 10'd0;
        tick();
        checkOutput("frame_tick low", {15'd0, frame_tick}, 16'd0);

        // Pause for three frames
        ft_start = ft_count;
        pause = 1'b1;
        runFrames(3);
        checkPos("paused", 10'd2, 1'b1, 10'd2, 1'b1);
        checkOutput("paused ticks", 16'(ft_count - ft_start), 16'd3);
        pause = 1'b0;
        runFrames(1);
        checkPos("resume", 10'd4, 1'b1, 10'd4, 1'b1);

        // Long run across every wall
        runFrames(221);
        checkPos("n223", 10'd446, 1'b1, 10'd446, 1'b1);
        runFrames(1);
        checkPos("n224 bottom", 10'd448, 1'b1, 10'd448, 1'b0);
        runFrames(79);
        checkPos("n303", 10'd606, 1'b1, 10'd290, 1'b0);
        runFrames(1);
        checkPos("n304 right", 10'd608, 1'b0, 10'd288, 1'b0);
        runFrames(1);
        checkPos("n305", 10'd606, 1'b0, 10'd286, 1'b0);
        runFrames(142);
        checkPos("n447", 10'd322, 1'b0, 10'd2, 1'b0);
        runFrames(1);
        checkPos("n448 top", 10'd320, 1'b0, 10'd0, 1'b1);
        runFrames(159);
        checkPos("n607", 10'd2, 1'b0, 10'd318, 1'b1);
        runFrames(1);
        checkPos("n608 left", 10'd0, 1'b1, 10'd320, 1'b1);

        // Box now at (0,320)
        sw = 12'h0A5;
        applyStimulus(10'd3, 10'd325, 1'b1, 1'b0, 1'b0);
        checkOutput("px(3,325)", {4'd0, rgb}, 16'h00A5);
        applyStimulus(10'd3, 10'd319, 1'b1, 1'b0, 1'b0);
        checkOutput("px(3,319)", {4'd0, rgb}, 16'h000F);
        applyStimulus(10'd32, 10'd325, 1'b1, 1'b0, 1'b0);
        checkOutput("px(32,325)", {4'd0, rgb}, 16'h000F);
        runFrames(1);
        checkPos("n609", 10'd2, 1'b1, 10'd322, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
